weight_fetch_unit: RTL and testbench
====================================

WEIGHT_FETCH_UNIT -- requirements
Module: weight_fetch_unit

Interface
REQ-001 SHALL provide parameter MUL_SIZE, default 32 (from tpu_package), meaning systolic array edge; one tile is MUL_SIZE rows.
REQ-002 SHALL provide parameter DATA_W, default 8, meaning bits per weight element.
REQ-003 SHALL provide parameter FIFO_DEPTH, default MUL_SIZE, meaning weight FIFO capacity in rows.
REQ-004 SHALL provide parameter ADDR_W, default 16, meaning weight memory address width.
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 SHALL have port clk_i, input, 1, clock.
REQ-007 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-008 SHALL have port instruction_i, input, 1, start pulse (same strobe sent to the control unit).
REQ-009 SHALL have ports H_DIM_i and W_DIM_i, input, 9 each, operand dimensions minus one.
REQ-010 SHALL have port weight_start_addr_i, input, ADDR_W, base row address of the weight matrix.
REQ-011 SHALL have ports weight_mem_rd_en_o (output, 1) and weight_mem_addr_o (output, ADDR_W), memory read request.
REQ-012 SHALL have port weight_mem_data_i, input, MUL_SIZE*DATA_W, read data, valid exactly 1 cycle after rd_en.
REQ-013 SHALL have port load_weights_i, input, 1, consumer pop request.
REQ-014 SHALL have ports weight_row_o (output, MUL_SIZE*DATA_W, FIFO head row) and weight_fifo_valid_o (output, 1, FIFO non-empty).
REQ-015 SHALL have ports fifo_full_o (output, 1, count==FIFO_DEPTH) and fetch_done_o (output, 1, one-cycle pulse after last row is written).

Function
REQ-016 Tile grid SHALL be HT=(H_DIM_i>>5)+1 by WT=(W_DIM_i>>5)+1, with tile_y as the inner loop and tile_x as the outer loop.
REQ-017 Row address SHALL be weight_start_addr + (tile_x*HT + tile_y)*MUL_SIZE + row, truncated to ADDR_W (wrap-around).
REQ-018 FSM states SHALL be IDLE, FETCH, DRAIN.
REQ-019 IDLE->FETCH SHALL occur on instruction_i, latching dims and base address and clearing the row/tile counters.
REQ-020 FETCH SHALL issue one read per cycle when (fifo count + reads in flight) < FIFO_DEPTH, otherwise hold.
REQ-021 FETCH->DRAIN SHALL occur on the read of the last row of tile (WT-1, HT-1).
REQ-022 DRAIN->IDLE SHALL occur when the final return is written, pulsing fetch_done_o for that cycle.
REQ-023 Returned data SHALL be pushed the cycle after the read; overflow is impossible by credit (REQ-020).
REQ-024 Pop SHALL occur on load_weights_i & weight_fifo_valid_o; weight_row_o SHALL advance on the next cycle; a pop when empty SHALL be ignored.
REQ-025 Simultaneous push and pop SHALL leave the count unchanged, including when the FIFO is full.
REQ-026 instruction_i outside IDLE SHALL be ignored.
REQ-027 The FIFO SHALL be first-in first-out, in row order.

Reset
REQ-028 rst_i SHALL force IDLE, empty the FIFO, zero all counters and the in-flight count, and drive every output to 0 (weight_row_o = 0), including mid-operation.
REQ-029 Memory data returning the cycle after a reset SHALL be discarded.

Configuration
REQ-030 With WEIGHT_FETCH_STALL_CNT_EN defined, output stall_cycles_o (16 bits) SHALL count FETCH cycles with no read issued, saturate at 16'hFFFF, clear on the IDLE->FETCH transition, and reset to 0.
REQ-031 Without the macro, stall_cycles_o SHALL be tied to 0 and the counter logic SHALL be absent.

Structure
REQ-032 MUL_SIZE and the fetch state enum typedef SHALL live in tpu_package.
REQ-033 The FIFO SHALL be a sub-module, weight_sync_fifo (parameterised width and depth, count output).

Verification
REQ-034 H=31, W=31, no pops: 32 reads at base+0..31, fifo_full_o=1, fetch_done_o pulses once, no read #33.
REQ-035 H=63, W=63, base=0x100, pop 1 row per cycle: read order 0x100..0x17F; the popped row sequence matches memory contents.
REQ-036 Full FIFO, then push and pop in the same cycle: count stays 32 and fifo_full_o stays 1.
REQ-037 Pop on an empty FIFO: no state change and weight_fifo_valid_o stays 0.
REQ-038 rst_i at read #10 of tile 1: next cycle IDLE, valid=0, full=0; the late return is not pushed.
REQ-039 Macro on, FIFO full for 5 FETCH cycles: stall_cycles_o=5; macro off: stall_cycles_o stays 0.

Source files
------------

// File: rtl/tpu_package.sv
// Shared TPU definitions: systolic array edge and the weight-fetch state encoding.
package tpu_package;

    localparam int unsigned MUL_SIZE = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/weight_sync_fifo.sv
// Synchronous FIFO with occupancy count; head is forced to zero while empty.
module weight_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [WIDTH-1:0]             data_i,
    output logic [WIDTH-1:0]             data_o,
    output logic                         valid_o,
    output logic                         full_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push_c;
    logic             do_pop_c;

    // A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
    assign do_pop_c  = pop_i && (count_q != '0);
    assign do_push_c = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop_c);

    always_ff @(posedge clk_i) begin
        if (do_push_c) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push_c) begin
                wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (do_pop_c) begin
                rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            case ({do_push_c, do_pop_c})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign valid_o = (count_q != '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/weight_fetch_unit.sv
// Streams weight tiles from memory into a row FIFO under credit flow control.
// Optional stall counter enabled by defining WEIGHT_FETCH_STALL_CNT_EN.
module weight_fetch_unit
    import tpu_package::*;
#(
    parameter int unsigned MUL_SIZE   = tpu_package::MUL_SIZE,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = MUL_SIZE,
    parameter int unsigned ADDR_W     = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         instruction_i,
    input  logic [8:0]                   H_DIM_i,
    input  logic [8:0]                   W_DIM_i,
    input  logic [ADDR_W-1:0]            weight_start_addr_i,
    output logic                         weight_mem_rd_en_o,
    output logic [ADDR_W-1:0]            weight_mem_addr_o,
    input  logic [MUL_SIZE*DATA_W-1:0]   weight_mem_data_i,
    input  logic                         load_weights_i,
    output logic [MUL_SIZE*DATA_W-1:0]   weight_row_o,
    output logic                         weight_fifo_valid_o,
    output logic                         fifo_full_o,
    output logic                         fetch_done_o,
    output logic [15:0]                  stall_cycles_o
);

    localparam int unsigned ROW_W  = MUL_SIZE * DATA_W;
    localparam int unsigned SHIFT  = $clog2(MUL_SIZE);
    localparam int unsigned RC_W   = (SHIFT > 0) ? SHIFT : 1;
    localparam int unsigned TILE_W = 9 - SHIFT;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);

    fetch_state_e      state_q;
    fetch_state_e      state_d;
    logic [TILE_W-1:0] ht_m1_q;
    logic [TILE_W-1:0] wt_m1_q;
    logic [ADDR_W-1:0] base_q;
    logic [RC_W-1:0]   row_q;
    logic [TILE_W-1:0] ty_q;
    logic [TILE_W-1:0] tx_q;
    logic              rd_en_q;
    logic [ADDR_W-1:0] addr_q;
    logic              pending_q;
    logic              done_q;
    logic [CNT_W-1:0]  fifo_count;

    logic              start_c;
    logic              credit_ok_c;
    logic              issue_c;
    logic              row_last_c;
    logic              last_read_c;
    logic              final_push_c;
    logic [31:0]       tile_idx_c;
    logic [ADDR_W-1:0] row_addr_c;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_c)                state_d = FETCH;
            FETCH:   if (issue_c && last_read_c) state_d = DRAIN;
            DRAIN:   if (final_push_c)           state_d = IDLE;
            default:                             state_d = IDLE;
        endcase
    end

    // Credits cover rows already stored plus both stages of the one-cycle read pipeline.
    always_comb begin
        start_c      = 1'b0;
        credit_ok_c  = 1'b0;
        issue_c      = 1'b0;
        final_push_c = 1'b0;
        row_last_c   = (row_q == RC_W'(MUL_SIZE - 1));
        last_read_c  = row_last_c && (ty_q == ht_m1_q) && (tx_q == wt_m1_q);
        tile_idx_c   = 32'(tx_q) * (32'(ht_m1_q) + 32'd1) + 32'(ty_q);
        row_addr_c   = base_q + ADDR_W'(tile_idx_c * MUL_SIZE + 32'(row_q));
        case (state_q)
            IDLE: begin
                start_c = instruction_i;
            end
            FETCH: begin
                credit_ok_c = (32'(fifo_count) + 32'(rd_en_q) + 32'(pending_q)) < FIFO_DEPTH;
                issue_c     = credit_ok_c;
            end
            DRAIN: begin
                final_push_c = pending_q && !rd_en_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ht_m1_q   <= '0;
            wt_m1_q   <= '0;
            base_q    <= '0;
            row_q     <= '0;
            ty_q      <= '0;
            tx_q      <= '0;
            rd_en_q   <= 1'b0;
            addr_q    <= '0;
            pending_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            if (start_c) begin
                ht_m1_q <= TILE_W'(H_DIM_i >> SHIFT);
                wt_m1_q <= TILE_W'(W_DIM_i >> SHIFT);
                base_q  <= weight_start_addr_i;
                row_q   <= '0;
                ty_q    <= '0;
                tx_q    <= '0;
            end else if (issue_c) begin
                if (row_last_c) begin
                    row_q <= '0;
                    if (ty_q == ht_m1_q) begin
                        ty_q <= '0;
                        tx_q <= tx_q + TILE_W'(1);
                    end else begin
                        ty_q <= ty_q + TILE_W'(1);
                    end
                end else begin
                    row_q <= row_q + RC_W'(1);
                end
            end
            rd_en_q   <= issue_c;
            if (issue_c) begin
                addr_q <= row_addr_c;
            end
            pending_q <= rd_en_q;
            done_q    <= final_push_c;
        end
    end

    weight_sync_fifo #(
        .WIDTH (ROW_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (pending_q),
        .pop_i   (load_weights_i),
        .data_i  (weight_mem_data_i),
        .data_o  (weight_row_o),
        .valid_o (weight_fifo_valid_o),
        .full_o  (fifo_full_o),
        .count_o (fifo_count)
    );

    assign weight_mem_rd_en_o = rd_en_q;
    assign weight_mem_addr_o  = addr_q;
    assign fetch_done_o       = done_q;

`ifdef WEIGHT_FETCH_STALL_CNT_EN
    logic [15:0] stall_q;

    // Counts FETCH cycles starved of credit; saturates rather than wrapping.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_q <= '0;
        end else if (start_c) begin
            stall_q <= '0;
        end else if ((state_q == FETCH) && !issue_c && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cycles_o = stall_q;
`else
    assign stall_cycles_o = '0;
`endif

endmodule

// File: tb/tb_weight_fetch_unit.sv
// Scoreboard bench for weight_fetch_unit: expected reads/rows queued by stimulus, checked by a monitor.
module tb_weight_fetch_unit;

    localparam int unsigned ROW_W = 256;

`ifdef WEIGHT_FETCH_STALL_CNT_EN
    localparam logic [15:0] STALL_EXP = 16'd5;
`else
    localparam logic [15:0] STALL_EXP = 16'd0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              instr = 1'b0;
    logic [8:0]        h_dim = '0;
    logic [8:0]        w_dim = '0;
    logic [15:0]       base_in = '0;
    logic              rd_en;
    logic [15:0]       rd_addr;
    logic [ROW_W-1:0]  mem_data = '0;
    logic              load = 1'b0;
    logic [ROW_W-1:0]  row_out;
    logic              fvalid;
    logic              ffull;
    logic              fdone;
    logic [15:0]       stall;

    logic              f_push = 1'b0;
    logic              f_pop = 1'b0;
    logic [7:0]        f_din = '0;
    logic [7:0]        f_dout;
    logic              f_valid;
    logic              f_full;
    logic [2:0]        f_count;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    logic [15:0]      exp_addr[$];
    logic [ROW_W-1:0] exp_row[$];

    always #5 clk = ~clk;

    weight_fetch_unit dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .instruction_i       (instr),
        .H_DIM_i             (h_dim),
        .W_DIM_i             (w_dim),
        .weight_start_addr_i (base_in),
        .weight_mem_rd_en_o  (rd_en),
        .weight_mem_addr_o   (rd_addr),
        .weight_mem_data_i   (mem_data),
        .load_weights_i      (load),
        .weight_row_o        (row_out),
        .weight_fifo_valid_o (fvalid),
        .fifo_full_o         (ffull),
        .fetch_done_o        (fdone),
        .stall_cycles_o      (stall)
    );

    weight_sync_fifo #(.WIDTH(8), .DEPTH(4)) u_small_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (f_push),
        .pop_i   (f_pop),
        .data_i  (f_din),
        .data_o  (f_dout),
        .valid_o (f_valid),
        .full_o  (f_full),
        .count_o (f_count)
    );

    function automatic logic [ROW_W-1:0] mem_row(input logic [15:0] a);
        logic [ROW_W-1:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i*8 +: 8] = 8'(a[7:0] + 8'(i * 37)) ^ a[15:8];
        end
        return r;
    endfunction

    // One-cycle read latency memory model.
    always @(posedge clk) mem_data <= rd_en ? mem_row(rd_addr) : '0;

    task automatic chk(input string nm, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // Monitor: compares every issued read and every popped row against the queues.
    always @(negedge clk) begin
        if (rd_en) begin
            if (exp_addr.size() == 0) chk("unexpected_read", ROW_W'(rd_addr), ROW_W'(17'h10000));
            else chk("rd_addr", ROW_W'(rd_addr), ROW_W'(exp_addr.pop_front()));
        end
        if (load && fvalid) begin
            if (exp_row.size() == 0) chk("unexpected_pop", row_out, '1);
            else chk("pop_row", row_out, exp_row.pop_front());
        end
        if (fdone) done_cnt++;
    end

    task automatic start(input logic [8:0] h, input logic [8:0] w, input logic [15:0] b);
        @(posedge clk); #1;
        h_dim = h; w_dim = w; base_in = b; instr = 1'b1;
        @(posedge clk); #1;
        instr = 1'b0;
    endtask

    task automatic queue_reads(input logic [15:0] b, input int n, input bit rows);
        for (int i = 0; i < n; i++) begin
            exp_addr.push_back(16'(b + 16'(i)));
            if (rows) exp_row.push_back(mem_row(16'(b + 16'(i))));
        end
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        int s = done_cnt;
        while (done_cnt == s && n < limit) begin @(negedge clk); n++; end
        if (done_cnt == s) chk("done_timeout", 0, 1);
    endtask

    task automatic wait_empty(input int limit);
        int n = 0;
        while (fvalid && n < limit) begin @(negedge clk); n++; end
        chk("drain_empty", ROW_W'(fvalid), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_rd_en", ROW_W'(rd_en), 0);
        chk("rst_addr", ROW_W'(rd_addr), 0);
        chk("rst_valid", ROW_W'(fvalid), 0);
        chk("rst_full", ROW_W'(ffull), 0);
        chk("rst_done", ROW_W'(fdone), 0);
        chk("rst_row", row_out, 0);
        chk("rst_stall", ROW_W'(stall), 0);

        // Single tile, no pops, base near top of memory so addresses wrap.
        done_cnt = 0;
        queue_reads(16'hFFF0, 32, 1'b0);
        start(9'd31, 9'd31, 16'hFFF0);
        wait_done(200);
        repeat (10) @(negedge clk);
        chk("t1_full", ROW_W'(ffull), 1);
        chk("t1_valid", ROW_W'(fvalid), 1);
        chk("t1_done_once", ROW_W'(done_cnt), 1);
        chk("t1_reads_left", ROW_W'(exp_addr.size()), 0);
        chk("t1_head", row_out, mem_row(16'hFFF0));
        chk("t1_stall", ROW_W'(stall), 0);
        queue_reads(16'hFFF0, 32, 1'b1);
        exp_addr.delete();
        @(posedge clk); #1 load = 1'b1;
        wait_empty(100);
        #1 load = 1'b0;
        chk("t1_rows_left", ROW_W'(exp_row.size()), 0);

        // Pop while empty changes nothing.
        @(posedge clk); #1 load = 1'b1;
        repeat (3) @(negedge clk);
        chk("empty_pop_valid", ROW_W'(fvalid), 0);
        chk("empty_pop_row", row_out, 0);
        chk("empty_pop_full", ROW_W'(ffull), 0);
        @(posedge clk); #1 load = 1'b0;

        // 2x2 tiles with continuous pops; a second start mid-run must be ignored.
        done_cnt = 0;
        queue_reads(16'h0100, 128, 1'b1);
        @(posedge clk); #1 load = 1'b1;
        start(9'd63, 9'd63, 16'h0100);
        repeat (20) @(posedge clk);
        start(9'd0, 9'd0, 16'h3000);
        wait_done(1000);
        wait_empty(100);
        #1 load = 1'b0;
        chk("t2_done_once", ROW_W'(done_cnt), 1);
        chk("t2_reads_left", ROW_W'(exp_addr.size()), 0);
        chk("t2_rows_left", ROW_W'(exp_row.size()), 0);

        // Two tiles, no pops: FIFO fills and FETCH stalls for five cycles.
        queue_reads(16'h0200, 64, 1'b0);
        start(9'd63, 9'd31, 16'h0200);
        repeat (37) @(posedge clk);
        @(negedge clk);
        chk("stall_cnt", ROW_W'(stall), ROW_W'(STALL_EXP));
        chk("stall_full", ROW_W'(ffull), 1);
        chk("stall_no_read", ROW_W'(rd_en), 0);

        // Resume with pops, then reset on read #10 of tile 1.
        for (int i = 0; i < 64; i++) exp_row.push_back(mem_row(16'(16'h0200 + 16'(i))));
        @(posedge clk); #1 load = 1'b1;
        begin
            int n = 0;
            @(negedge clk);
            while (!(rd_en && rd_addr == 16'h022A) && n < 200) begin @(negedge clk); n++; end
            chk("hit_read42", ROW_W'(rd_addr), ROW_W'(16'h022A));
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; load = 1'b0;
        exp_addr.delete();
        exp_row.delete();
        @(negedge clk);
        chk("mid_rst_rd_en", ROW_W'(rd_en), 0);
        chk("mid_rst_valid", ROW_W'(fvalid), 0);
        chk("mid_rst_full", ROW_W'(ffull), 0);
        chk("mid_rst_row", row_out, 0);
        chk("mid_rst_stall", ROW_W'(stall), 0);
        repeat (3) @(negedge clk);
        chk("late_return_dropped", ROW_W'(fvalid), 0);

        // Push and pop together on a full FIFO keep it full.
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1 f_push = 1'b1; f_din = 8'(i * 17);
        end
        @(posedge clk); #1 f_push = 1'b0;
        @(negedge clk);
        chk("f_count_full", ROW_W'(f_count), 4);
        chk("f_full", ROW_W'(f_full), 1);
        chk("f_head0", ROW_W'(f_dout), ROW_W'(8'h11));
        @(posedge clk); #1 f_push = 1'b1; f_pop = 1'b1; f_din = 8'h55;
        @(posedge clk); #1 f_push = 1'b0; f_pop = 1'b0;
        @(negedge clk);
        chk("f_pp_count", ROW_W'(f_count), 4);
        chk("f_pp_full", ROW_W'(f_full), 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("f_order", ROW_W'(f_dout), ROW_W'(8'(8'h22 + 8'(i * 17))));
            @(posedge clk); #1 f_pop = 1'b1;
            @(posedge clk); #1 f_pop = 1'b0;
        end
        @(negedge clk);
        chk("f_empty", ROW_W'(f_valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
